// File: rtl/coa_pkg.sv
// Shared definitions for the COA result consumer: data width, sign classes
// and the per-frame statistics record.
package coa_pkg;

  localparam int COA_DW    = 10;
  localparam int COA_CNT_W = 8;

  localparam logic [1:0] CLS_ACUTE  = 2'd0;
  localparam logic [1:0] CLS_RIGHT  = 2'd1;
  localparam logic [1:0] CLS_OBTUSE = 2'd2;

  // Count fields are sized for the largest supported frame; users slice to CW.
  typedef struct packed {
    logic [COA_CNT_W-1:0]     cnt;
    logic [COA_CNT_W-1:0]     acute;
    logic [COA_CNT_W-1:0]     right;
    logic [COA_CNT_W-1:0]     obtuse;
    logic signed [COA_DW-1:0] max;
    logic signed [COA_DW-1:0] min;
  } coa_stat_t;

  function automatic logic [1:0] classify(input logic signed [COA_DW-1:0] d);
    if (d > 0)       return CLS_ACUTE;
    else if (d == 0) return CLS_RIGHT;
    else             return CLS_OBTUSE;
  endfunction

endpackage

// File: rtl/coa_frame_acc.sv
// Frame accumulator: classifies each sample, tracks counts and extremes,
// and pulses close with the finished record (including any same-cycle sample).
module coa_frame_acc
  import coa_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [COA_DW-1:0] d,
  input  logic                     flush,
  output logic                     close,
  output coa_stat_t                stat
);

  typedef enum logic {EMPTY, ACC} acc_state_t;

  acc_state_t               state_q, state_n;
  logic [CW-1:0]            cnt_q, cnt_n;
  logic [CW-1:0]            acute_q, acute_n;
  logic [CW-1:0]            right_q, right_n;
  logic [CW-1:0]            obtuse_q, obtuse_n;
  logic signed [COA_DW-1:0] max_q, max_n;
  logic signed [COA_DW-1:0] min_q, min_n;
  logic [1:0]               cls;

  always_comb begin
    cls      = classify(d);
    cnt_n    = cnt_q;
    acute_n  = acute_q;
    right_n  = right_q;
    obtuse_n = obtuse_q;
    max_n    = max_q;
    min_n    = min_q;
    state_n  = state_q;
    if (valid_in) begin
      cnt_n = cnt_q + CW'(1);
      case (cls)
        CLS_ACUTE: acute_n  = acute_q + CW'(1);
        CLS_RIGHT: right_n  = right_q + CW'(1);
        default:   obtuse_n = obtuse_q + CW'(1);
      endcase
      // The first sample of a frame seeds both extremes.
      if (state_q == EMPTY || d > max_q) max_n = d;
      if (state_q == EMPTY || d < min_q) min_n = d;
    end
    close = (valid_in && cnt_n == CW'(FRAME_LEN)) || (flush && cnt_n != '0);
    if (close)         state_n = EMPTY;
    else if (valid_in) state_n = ACC;
    stat.cnt    = COA_CNT_W'(cnt_n);
    stat.acute  = COA_CNT_W'(acute_n);
    stat.right  = COA_CNT_W'(right_n);
    stat.obtuse = COA_CNT_W'(obtuse_n);
    stat.max    = max_n;
    stat.min    = min_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      acute_q  <= '0;
      right_q  <= '0;
      obtuse_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
    end else begin
      state_q <= state_n;
      if (close) begin
        cnt_q    <= '0;
        acute_q  <= '0;
        right_q  <= '0;
        obtuse_q <= '0;
        max_q    <= '0;
        min_q    <= '0;
      end else begin
        cnt_q    <= cnt_n;
        acute_q  <= acute_n;
        right_q  <= right_n;
        obtuse_q <= obtuse_n;
        max_q    <= max_n;
        min_q    <= min_n;
      end
    end
  end

endmodule

// File: rtl/coa_frame_stat.sv
// Per-frame statistics of the COA result stream, presented one record per
// frame through a single-entry valid/ready slot with a sticky drop flag.
module coa_frame_stat
  import coa_pkg::*;
#(
  parameter int DW        = COA_DW,
  parameter int FRAME_LEN = 16,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] D,
  input  logic                 flush,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [CW-1:0]        res_cnt,
  output logic [CW-1:0]        res_acute,
  output logic [CW-1:0]        res_right,
  output logic [CW-1:0]        res_obtuse,
  output logic signed [DW-1:0] res_max,
  output logic signed [DW-1:0] res_min,
  output logic                 ovf
);

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  out_state_t out_state_q, out_state_n;
  coa_stat_t  stat, slot_q;
  logic       close, drain, load, ovf_q;

  coa_frame_acc #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .d        (D),
    .flush    (flush),
    .close    (close),
    .stat     (stat)
  );

  // A draining slot can take the new record in the same cycle, so no bubble.
  always_comb begin
    drain       = (out_state_q == OUT_FULL) && res_ready;
    load        = close && ((out_state_q == OUT_EMPTY) || drain);
    out_state_n = out_state_q;
    if (load)       out_state_n = OUT_FULL;
    else if (drain) out_state_n = OUT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= OUT_EMPTY;
      slot_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_state_q <= out_state_n;
      if (load)          slot_q <= stat;
      if (close && !load) ovf_q <= 1'b1;
    end
  end

  assign res_valid  = (out_state_q == OUT_FULL);
  assign res_cnt    = slot_q.cnt[CW-1:0];
  assign res_acute  = slot_q.acute[CW-1:0];
  assign res_right  = slot_q.right[CW-1:0];
  assign res_obtuse = slot_q.obtuse[CW-1:0];
  assign res_max    = slot_q.max;
  assign res_min    = slot_q.min;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_coa_frame_stat.sv
// Scoreboard bench for coa_frame_stat with FRAME_LEN=4: directed scenarios
// followed by random traffic, checked against a frame-level reference model.
module tb_coa_frame_stat;

  localparam int FL = 4;
  localparam int DW = 10;
  localparam int CW = $clog2(FL + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_in = 1'b0;
  logic                 flush = 1'b0;
  logic                 res_ready = 1'b0;
  logic signed [DW-1:0] D = '0;
  logic                 res_valid;
  logic [CW-1:0]        res_cnt, res_acute, res_right, res_obtuse;
  logic signed [DW-1:0] res_max, res_min;
  logic                 ovf;

  typedef struct {
    int cnt;
    int acute;
    int right;
    int obtuse;
    int mx;
    int mn;
  } rec_t;

  rec_t exp_q[$];
  int   frame_q[$];
  bit   m_full = 1'b0;
  bit   m_ovf = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  coa_frame_stat #(
    .DW        (DW),
    .FRAME_LEN (FL),
    .CW        (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .D          (D),
    .flush      (flush),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_cnt    (res_cnt),
    .res_acute  (res_acute),
    .res_right  (res_right),
    .res_obtuse (res_obtuse),
    .res_max    (res_max),
    .res_min    (res_min),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t summarize();
    rec_t r;
    r.cnt = frame_q.size();
    r.acute = 0;
    r.right = 0;
    r.obtuse = 0;
    r.mx = frame_q[0];
    r.mn = frame_q[0];
    foreach (frame_q[i]) begin
      if (frame_q[i] > 0)       r.acute++;
      else if (frame_q[i] == 0) r.right++;
      else                      r.obtuse++;
      if (frame_q[i] > r.mx) r.mx = frame_q[i];
      if (frame_q[i] < r.mn) r.mn = frame_q[i];
    end
    return r;
  endfunction

  // One clock of stimulus; the model decides what a frame close produces.
  task automatic apply_stimulus(input bit r, input bit v, input int d, input bit f, input bit rdy);
    bit drain;
    bit close;
    rst       = r;
    valid_in  = v;
    D         = DW'(d);
    flush     = f;
    res_ready = rdy;
    if (r) begin
      frame_q.delete();
      exp_q.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      drain = m_full && rdy;
      if (v) frame_q.push_back(d);
      close = (v && frame_q.size() == FL) || (f && frame_q.size() > 0);
      if (close) begin
        if (!m_full || drain) begin
          exp_q.push_back(summarize());
          m_full = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        frame_q.delete();
      end else if (drain) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_output("res_valid", int'(res_valid), int'(m_full));
    check_output("ovf", int'(ovf), int'(m_ovf));
  endtask

  always @(negedge clk) begin : monitor
    rec_t e;
    if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_record", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("res_cnt", int'(res_cnt), e.cnt);
        check_output("res_acute", int'(res_acute), e.acute);
        check_output("res_right", int'(res_right), e.right);
        check_output("res_obtuse", int'(res_obtuse), e.obtuse);
        check_output("res_max", int'(res_max), e.mx);
        check_output("res_min", int'(res_min), e.mn);
        check_output("class_sum", int'(res_acute) + int'(res_right) + int'(res_obtuse), int'(res_cnt));
      end
    end
  end

  initial begin
    int seq2[4] = '{5, 0, -3, 7};
    int seq5[4] = '{511, -512, 0, 511};
    int guard;

    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'(i % 2 == 0), 3, 1'b0, 1'b1);
      check_output("rst_cnt", int'(res_cnt), 0);
      check_output("rst_max", int'(res_max), 0);
      check_output("rst_min", int'(res_min), 0);
    end
    apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check_output("post_rst_acute", int'(res_acute), 0);

    foreach (seq2[i]) apply_stimulus(1'b0, 1'b1, seq2[i], 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

    apply_stimulus(1'b0, 1'b1, -1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, -2, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

    foreach (seq5[i]) apply_stimulus(1'b0, 1'b1, seq5[i], 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) apply_stimulus(1'b0, 1'b1, i, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, -4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, -7, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 2, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      apply_stimulus(1'($urandom_range(0, 149) == 0),
                     1'($urandom_range(0, 9) < 7),
                     int'($urandom_range(0, 1023)) - 512,
                     1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 3) != 0));
    end

    guard = 0;
    while ((exp_q.size() != 0 || m_full) && guard < 20) begin
      apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
      guard++;
    end
    check_output("records_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
